wb_port_arbiter: RTL and testbench

Writeback arbiter that sequences all register-file writes onto the two write ports of the dual-issue register file. It merges the two in-order pipeline lanes (A older, B younger) with a long-latency result stream (load/mul-div) buffered in a small FIFO. It resolves same-cycle destination collisions by program order and drops x0 writes. It sits between the writeback stage and the register file, driving `write_enable[1:0]`, `waddrA/wdataA` and `waddrB/wdataB`.

---
 rtl/wb_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: merges lanes A/B and a buffered long-latency stream onto two RF write ports.
// Optional starvation stall is compiled in when WB_STARVE_EN is defined.
module wb_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          a_valid,
  input  logic [ADDR_WIDTH-1:0]         a_rd,
  input  logic [DATA_WIDTH-1:0]         a_data,
  input  logic                          b_valid,
  input  logic [ADDR_WIDTH-1:0]         b_rd,
  input  logic [DATA_WIDTH-1:0]         b_data,
  input  logic                          l_valid,
  output logic                          l_ready,
  input  logic [ADDR_WIDTH-1:0]         l_rd,
  input  logic [DATA_WIDTH-1:0]         l_data,
  output logic [1:0]                    write_enable,
  output logic [ADDR_WIDTH-1:0]         waddrA,
  output logic [DATA_WIDTH-1:0]         wdataA,
  output logic [ADDR_WIDTH-1:0]         waddrB,
  output logic [DATA_WIDTH-1:0]         wdataB,
  output logic                          stall,
  output logic [$clog2(FIFO_DEPTH):0]   pending_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("wb_port_arbiter: invalid FIFO_DEPTH or STARVE_LIMIT");
  end

  logic [ADDR_WIDTH-1:0] rd_mem_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_nx;
  logic [CW-1:0]         count_q, count_d;
  logic [1:0]            pop_n;
  logic                  stall_int, lane_en, a_live, b_live, has1, has2, store;
  logic [ADDR_WIDTH-1:0] h0_rd, h1_rd;
  logic [DATA_WIDTH-1:0] h0_data, h1_data;

  assign rd_ptr_nx = rd_ptr_q + 1'b1;
  assign h0_rd     = rd_mem_q[rd_ptr_q];
  assign h0_data   = data_mem_q[rd_ptr_q];
  assign h1_rd     = rd_mem_q[rd_ptr_nx];
  assign h1_data   = data_mem_q[rd_ptr_nx];
  assign has1      = (count_q != '0);
  assign has2      = (count_q >= CW'(2));

  // While stalled the lanes are ignored so both ports belong to the FIFO.
  assign lane_en = reset && !stall_int;
  assign b_live  = lane_en && b_valid && (b_rd != '0);
  assign a_live  = lane_en && a_valid && (a_rd != '0) && !(b_live && (a_rd == b_rd));

  assign l_ready       = reset && (count_q < CW'(FIFO_DEPTH));
  assign store         = l_valid && l_ready && (l_rd != '0);
  assign pending_count = count_q;

  always_comb begin
    write_enable = 2'b00;
    waddrA       = '0;
    wdataA       = '0;
    waddrB       = '0;
    wdataB       = '0;
    pop_n        = 2'd0;
    if (a_live) begin
      write_enable[1] = 1'b1;
      waddrA          = a_rd;
      wdataA          = a_data;
    end
    if (b_live) begin
      write_enable[0] = 1'b1;
      waddrB          = b_rd;
      wdataB          = b_data;
    end
    // A popped entry aliasing a live lane rd is older, so it is consumed silently.
    if (!a_live && has1) begin
      pop_n = 2'd1;
      if (!(b_live && (h0_rd == b_rd))) begin
        write_enable[1] = 1'b1;
        waddrA          = h0_rd;
        wdataA          = h0_data;
      end
      if (!b_live && has2) begin
        pop_n           = 2'd2;
        write_enable[0] = 1'b1;
        waddrB          = h1_rd;
        wdataB          = h1_data;
      end
    end else if (a_live && !b_live && has1) begin
      pop_n = 2'd1;
      if (h0_rd != a_rd) begin
        write_enable[0] = 1'b1;
        waddrB          = h0_rd;
        wdataB          = h0_data;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(store);
    rd_ptr_d = rd_ptr_q + PW'(pop_n);
    count_d  = count_q + CW'(store) - CW'(pop_n);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      rd_mem_q[wr_ptr_q]   <= l_rd;
      data_mem_q[wr_ptr_q] <= l_data;
    end
  end

`ifdef WB_STARVE_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] wait_q, wait_d;
  logic          stall_q, stall_d;

  always_comb begin
    if (!has1 || (pop_n != 2'd0)) begin
      wait_d = '0;
    end else if (wait_q < SW'(STARVE_LIMIT)) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end
    stall_d = has1 && (pop_n == 2'd0) && (stall_q || (wait_d == SW'(STARVE_LIMIT)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign stall_int = stall_q;
`else
  assign stall_int = 1'b0;
`endif

  assign stall = stall_int;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Table-driven, queue-scoreboarded bench for wb_port_arbiter (default parameters).
module tb_wb_port_arbiter;

`ifdef WB_STARVE_EN
  localparam logic STARVE = 1'b1;
`else
  localparam logic STARVE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, l_valid, l_ready, stall;
  logic [4:0]  a_rd, b_rd, l_rd, waddrA, waddrB;
  logic [31:0] a_data, b_data, l_data, wdataA, wdataB;
  logic [1:0]  write_enable, pending_count;

  wb_port_arbiter #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (5),
    .FIFO_DEPTH  (2),
    .STARVE_LIMIT(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .a_valid      (a_valid),
    .a_rd         (a_rd),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_rd         (b_rd),
    .b_data       (b_data),
    .l_valid      (l_valid),
    .l_ready      (l_ready),
    .l_rd         (l_rd),
    .l_data       (l_data),
    .write_enable (write_enable),
    .waddrA       (waddrA),
    .wdataA       (wdataA),
    .waddrB       (waddrB),
    .wdataB       (wdataB),
    .stall        (stall),
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        bv;  logic [4:0] brd; logic [31:0] bd;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic [1:0]  we;
    logic [4:0]  wa;  logic [31:0] wda;
    logic [4:0]  wb;  logic [31:0] wdb;
    logic [1:0]  pend;
    logic        lr;
    logic        st;
  } vec_t;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa;  logic [31:0] wda;
    logic [4:0]  wb;  logic [31:0] wdb;
    logic [1:0]  pend;
    logic        lr;
    logic        st;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(
    input logic rst,
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic bv, input logic [4:0] brd, input logic [31:0] bd,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
    input logic [1:0] we, input logic [4:0] wa, input logic [31:0] wda,
    input logic [4:0] wb, input logic [31:0] wdb,
    input logic [1:0] pend, input logic lr, input logic st);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard; v.ad = ad;
    v.bv = bv; v.brd = brd; v.bd = bd;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.we = we; v.wa = wa; v.wda = wda; v.wb = wb; v.wdb = wdb;
    v.pend = pend; v.lr = lr; v.st = st;
    return v;
  endfunction

  task automatic chk(input string nm, input int unsigned row, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row%0d got=0x%0h want=0x%0h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset   = v.rst;
    a_valid = v.av; a_rd = v.ard; a_data = v.ad;
    b_valid = v.bv; b_rd = v.brd; b_data = v.bd;
    l_valid = v.lv; l_rd = v.lrd; l_data = v.ld;
  endtask

  initial begin
    exp_t e;
    vec_t idle;
    // rst | A lane | B lane | L stream | we, A port, B port, pend, l_ready, stall
    vecs.push_back(mk(0, 0,0,0,       0,0,0,       0,0,0,       2'b00, 0,0,       0,0,       0,0,0));
    vecs.push_back(mk(1, 0,0,0,       0,0,0,       0,0,0,       2'b00, 0,0,       0,0,       0,1,0));
    vecs.push_back(mk(1, 1,5,32'h11,  1,5,32'h22,  0,0,0,       2'b01, 0,0,       5,32'h22,  0,1,0));
    vecs.push_back(mk(1, 1,0,32'h33,  0,0,0,       0,0,0,       2'b00, 0,0,       0,0,       0,1,0));
    vecs.push_back(mk(1, 0,0,0,       0,0,0,       1,7,32'hAA,  2'b00, 0,0,       0,0,       0,1,0));
    vecs.push_back(mk(1, 0,0,0,       0,0,0,       0,0,0,       2'b10, 7,32'hAA,  0,0,       1,1,0));
    vecs.push_back(mk(1, 0,0,0,       0,0,0,       0,0,0,       2'b00, 0,0,       0,0,       0,1,0));
    vecs.push_back(mk(1, 1,1,32'h1,   1,2,32'h2,   1,3,32'h33,  2'b11, 1,32'h1,   2,32'h2,   0,1,0));
    vecs.push_back(mk(1, 1,1,32'h1,   1,2,32'h2,   1,4,32'h44,  2'b11, 1,32'h1,   2,32'h2,   1,1,0));
    vecs.push_back(mk(1, 1,1,32'h1,   1,2,32'h2,   0,0,0,       2'b11, 1,32'h1,   2,32'h2,   2,0,0));
    vecs.push_back(mk(1, 1,9,32'h99,  0,0,0,       0,0,0,       2'b11, 9,32'h99,  3,32'h33,  2,0,0));
    vecs.push_back(mk(1, 0,0,0,       0,0,0,       0,0,0,       2'b10, 4,32'h44,  0,0,       1,1,0));
    vecs.push_back(mk(1, 0,0,0,       0,0,0,       1,6,32'h66,  2'b00, 0,0,       0,0,       0,1,0));
    vecs.push_back(mk(1, 0,0,0,       1,6,32'h77,  0,0,0,       2'b01, 0,0,       6,32'h77,  1,1,0));
    vecs.push_back(mk(1, 0,0,0,       0,0,0,       0,0,0,       2'b00, 0,0,       0,0,       0,1,0));
    vecs.push_back(mk(1, 1,1,32'h1,   1,2,32'h2,   1,8,32'h88,  2'b11, 1,32'h1,   2,32'h2,   0,1,0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 1,1,32'h1, 1,2,32'h2,   0,0,0,       2'b11, 1,32'h1,   2,32'h2,   1,1,0));
    vecs.push_back(mk(1, 0,0,0,       0,0,0,       0,0,0,       2'b10, 8,32'h88,  0,0,       1,1,STARVE));
    vecs.push_back(mk(1, 0,0,0,       0,0,0,       0,0,0,       2'b00, 0,0,       0,0,       0,1,0));
    vecs.push_back(mk(1, 0,0,0,       0,0,0,       1,0,32'h55,  2'b00, 0,0,       0,0,       0,1,0));
    vecs.push_back(mk(1, 0,0,0,       0,0,0,       0,0,0,       2'b00, 0,0,       0,0,       0,1,0));
    vecs.push_back(mk(1, 1,1,32'h1,   1,2,32'h2,   1,10,32'hA0, 2'b11, 1,32'h1,   2,32'h2,   0,1,0));
    vecs.push_back(mk(1, 1,1,32'h1,   1,2,32'h2,   1,11,32'hB1, 2'b11, 1,32'h1,   2,32'h2,   1,1,0));
    vecs.push_back(mk(1, 0,0,0,       0,0,0,       0,0,0,       2'b11, 10,32'hA0, 11,32'hB1, 2,0,0));
    vecs.push_back(mk(1, 0,0,0,       0,0,0,       0,0,0,       2'b00, 0,0,       0,0,       0,1,0));

    idle = mk(1, 0,0,0, 0,0,0, 0,0,0, 2'b00, 0,0, 0,0, 0,1,0);
    drive(vecs[0]);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      e.we = vecs[i].we; e.wa = vecs[i].wa; e.wda = vecs[i].wda;
      e.wb = vecs[i].wb; e.wdb = vecs[i].wdb; e.pend = vecs[i].pend;
      e.lr = vecs[i].lr; e.st = vecs[i].st;
      exp_q.push_back(e);
      #3;
      e = exp_q.pop_front();
      chk("write_enable", i, 32'(write_enable), 32'(e.we));
      chk("waddrA", i, 32'(waddrA), 32'(e.wa));
      chk("wdataA", i, wdataA, e.wda);
      chk("waddrB", i, 32'(waddrB), 32'(e.wb));
      chk("wdataB", i, wdataB, e.wdb);
      chk("pending_count", i, 32'(pending_count), 32'(e.pend));
      chk("l_ready", i, 32'(l_ready), 32'(e.lr));
      chk("stall", i, 32'(stall), 32'(e.st));
    end

    // Mid-traffic reset with two entries buffered and lanes still asserting.
    @(posedge clk); #1;
    drive(mk(1, 1,1,32'h1, 1,2,32'h2, 1,12,32'hC0, 2'b11, 0,0, 0,0, 0,0,0));
    @(posedge clk); #1;
    drive(mk(1, 1,1,32'h1, 1,2,32'h2, 1,13,32'hD0, 2'b11, 0,0, 0,0, 0,0,0));
    @(posedge clk); #1;
    drive(mk(1, 1,1,32'h1, 1,2,32'h2, 0,0,0,       2'b11, 0,0, 0,0, 0,0,0));
    #2;
    chk("mid_pending_before", 100, 32'(pending_count), 32'd2);
    chk("mid_lready_before", 100, 32'(l_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_pending_rst", 101, 32'(pending_count), 32'd0);
    chk("mid_lready_rst", 101, 32'(l_ready), 32'd0);
    chk("mid_we_rst", 101, 32'(write_enable), 32'd0);
    chk("mid_stall_rst", 101, 32'(stall), 32'd0);
    @(posedge clk); #1;
    drive(idle);
    #2;
    chk("mid_pending_rel", 102, 32'(pending_count), 32'd0);
    chk("mid_lready_rel", 102, 32'(l_ready), 32'd1);
    chk("mid_we_rel", 102, 32'(write_enable), 32'd0);
    @(posedge clk); #3;
    chk("mid_we_after", 103, 32'(write_enable), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
